// File: rtl/edge_detect_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_detect_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   // Wide enough to hold FILTER_CYCLES itself.
   function automatic int unsigned filter_count_width(int unsigned filter_cycles);
      return $clog2(filter_cycles) + 1;
   endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// One channel: synchroniser, glitch filter, registered rise/fall pulses,
// mode qualification, sticky flag and saturating edge counter.
module edge_detect_channel
   import edge_detect_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 1,
   parameter int unsigned COUNT_WIDTH   = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   signal,
   input  edge_mode_t             mode,
   input  logic                   clear,
   output logic                   level,
   output logic                   rise_pulse,
   output logic                   fall_pulse,
   output logic                   edge_pulse,
   output logic                   edge_flag,
   output logic [COUNT_WIDTH-1:0] edge_count,
   output logic                   overflow
);

   localparam int unsigned FCW = filter_count_width(FILTER_CYCLES);
   localparam logic [FCW-1:0] FILTER_LAST = FCW'(FILTER_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FCW-1:0]         filt_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q     <= '0;
         filt_q     <= '0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], signal};
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         if (s == level) begin
            filt_q <= '0;
         end else if (filt_q == FILTER_LAST) begin
            // Final mismatching sample: commit the level and pulse together.
            filt_q     <= '0;
            level      <= s;
            rise_pulse <= s;
            fall_pulse <= ~s;
         end else begin
            filt_q <= filt_q + 1'b1;
         end
      end
   end

   assign edge_pulse = (rise_pulse && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
                       (fall_pulse && (mode == EDGE_FALL || mode == EDGE_BOTH));

   always_ff @(posedge clock) begin
      if (reset) begin
         edge_flag  <= 1'b0;
         edge_count <= '0;
         overflow   <= 1'b0;
      end else if (edge_pulse) begin
         edge_flag <= 1'b1;
         // A coincident clear restarts the count with this event included.
         if (clear) begin
            edge_count <= COUNT_WIDTH'(1);
            overflow   <= 1'b0;
         end else if (edge_count == COUNT_MAX) begin
            overflow <= 1'b1;
         end else begin
            edge_count <= edge_count + 1'b1;
         end
      end else if (clear) begin
         edge_flag  <= 1'b0;
         edge_count <= '0;
         overflow   <= 1'b0;
      end
   end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: independent channels, port slicing only.
module edge_detect_multi
   import edge_detect_pkg::*;
#(
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 1,
   parameter int unsigned COUNT_WIDTH   = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [CHANNELS-1:0]             signal,
   input  logic [2*CHANNELS-1:0]           mode,
   input  logic [CHANNELS-1:0]             clear,
   output logic [CHANNELS-1:0]             level,
   output logic [CHANNELS-1:0]             rise_pulse,
   output logic [CHANNELS-1:0]             fall_pulse,
   output logic [CHANNELS-1:0]             edge_pulse,
   output logic [CHANNELS-1:0]             edge_flag,
   output logic [CHANNELS*COUNT_WIDTH-1:0] edge_count,
   output logic [CHANNELS-1:0]             overflow
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      edge_detect_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES),
         .COUNT_WIDTH   (COUNT_WIDTH)
      ) u_chan (
         .clock      (clock),
         .reset      (reset),
         .signal     (signal[i]),
         .mode       (edge_mode_t'(mode[2*i +: 2])),
         .clear      (clear[i]),
         .level      (level[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .edge_pulse (edge_pulse[i]),
         .edge_flag  (edge_flag[i]),
         .edge_count (edge_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
         .overflow   (overflow[i])
      );
   end

endmodule
